instruction_loader: RTL and testbench

Boot-time loader sitting directly upstream of the single-cycle RISC-V core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them, little-endian word-aligned, into the core's byte-addressed instruction memory. It pads the unused remainder with NOPs and holds the core in reset until the image is complete. It then releases `core_reset` so the core starts fetching from PC 0.

---
 rtl/instruction_loader_if.sv | 21 ++
 rtl/instruction_loader.sv | 122 ++++++++++++
 tb/tb_instruction_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Stream and instruction-memory bus shared by the boot loader and its neighbours.
// The slave side is the loader; the master side is upstream plus the memory.
interface instruction_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instruction_loader.sv
// Boot loader: streams an instruction image into the core's memory, pads the tail
// with NOPs and holds the core in reset until the image is complete.
module instruction_loader #(
  parameter int          DEPTH      = 64,
  parameter int          RESET_HOLD = 4,
  parameter logic [31:0] NOP        = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  instruction_loader_if.slave          bus,
  output logic                         core_reset,
  output logic                         load_done,
  output logic [$clog2(DEPTH+1)-1:0]   word_count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, HOLD, RUN, ERR} state_t;

  state_t        state, state_next;
  logic [CW-1:0] idx, idx_next, idx_inc, word_count_next;
  logic [HW-1:0] hold_cnt, hold_cnt_next;
  logic          imem_we, imem_we_next;
  logic [63:0]   imem_addr, imem_addr_next;
  logic [31:0]   imem_wdata, imem_wdata_next;
  logic          core_reset_next, load_done_next, overflow_next;
  logic          handshake;

  // s_ready comes straight from the state register so upstream sees no loop through s_valid
  assign bus.s_ready    = (state == LOAD);
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = imem_wdata;

  assign handshake = bus.s_valid && (state == LOAD);
  assign idx_inc   = idx + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      hold_cnt   <= hold_cnt_next;
      imem_we    <= imem_we_next;
      imem_addr  <= imem_addr_next;
      imem_wdata <= imem_wdata_next;
      core_reset <= core_reset_next;
      load_done  <= load_done_next;
      word_count <= word_count_next;
      overflow   <= overflow_next;
    end
  end

  // Everything holds by default; the write strobe is a one-cycle pulse per word
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    hold_cnt_next   = hold_cnt;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr;
    imem_wdata_next = imem_wdata;
    core_reset_next = core_reset;
    load_done_next  = load_done;
    word_count_next = word_count;
    overflow_next   = overflow;

    case (state)
      IDLE: state_next = LOAD;

      LOAD: begin
        if (handshake) begin
          imem_we_next    = 1'b1;
          imem_addr_next  = 64'(idx) << 2;
          imem_wdata_next = bus.s_data;
          idx_next        = idx_inc;
          word_count_next = word_count + CW'(1);
          if (bus.s_last) begin
            state_next = (idx_inc < CW'(DEPTH)) ? PAD : HOLD;
          end else if (idx_inc == CW'(DEPTH)) begin
            state_next    = ERR;
            overflow_next = 1'b1;
          end
        end
      end

      PAD: begin
        imem_we_next    = 1'b1;
        imem_addr_next  = 64'(idx) << 2;
        imem_wdata_next = NOP;
        idx_next        = idx_inc;
        if (idx == CW'(DEPTH - 1)) state_next = HOLD;
      end

      // The first HOLD edge already drops imem_we, so release never overlaps a write
      HOLD: begin
        hold_cnt_next = hold_cnt + HW'(1);
        if (hold_cnt == HW'(RESET_HOLD - 1)) begin
          state_next      = RUN;
          core_reset_next = 1'b0;
          load_done_next  = 1'b1;
        end
      end

      RUN, ERR: state_next = state;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with DEPTH=8, RESET_HOLD=4.
// Expected values are hand-computed from the loader's timing rules.
module tb_instruction_loader;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic       clk;
  logic       reset;
  logic       core_reset;
  logic       load_done;
  logic [3:0] word_count;
  logic       overflow;
  logic [31:0] mem [DEPTH];
  int checks;
  int errors;

  instruction_loader_if bus ();

  instruction_loader #(.DEPTH(DEPTH), .RESET_HOLD(4), .NOP(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .load_done  (load_done),
    .word_count (word_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: captures whatever the loader presents on the write strobe
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEADBEEF;
    end else if (bus.imem_we) begin
      mem[bus.imem_addr[4:2]] <= bus.imem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    tick();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_s_ready"},    bus.s_ready,    0);
    check_output({tag, "_imem_we"},    bus.imem_we,    0);
    check_output({tag, "_imem_addr"},  bus.imem_addr,  0);
    check_output({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    check_output({tag, "_core_reset"}, core_reset,     1);
    check_output({tag, "_load_done"},  load_done,      0);
    check_output({tag, "_word_count"}, word_count,     0);
    check_output({tag, "_overflow"},   overflow,       0);
  endtask

  initial begin
    logic [31:0] img [3];
    checks = 0;
    errors = 0;
    img[0] = 32'h00500093;
    img[1] = 32'h00A00113;
    img[2] = 32'h002081B3;
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset state, then IDLE -> LOAD
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check_output("ready_after_idle", bus.s_ready, 1);

    // Three-word image back to back, then five NOP pads and four hold cycles
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(img[i], i == 2);
      check_output("t1_we",   bus.imem_we,    1);
      check_output("t1_addr", bus.imem_addr,  64'(i * 4));
      check_output("t1_data", bus.imem_wdata, img[i]);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("t1_pad_we",    bus.imem_we,    1);
      check_output("t1_pad_addr",  bus.imem_addr,  64'(12 + 4 * i));
      check_output("t1_pad_data",  bus.imem_wdata, NOP);
      check_output("t1_pad_ready", bus.s_ready,    0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("t1_hold_we",  bus.imem_we, 0);
      check_output("t1_hold_crst", core_reset, 1);
    end
    tick();
    check_output("t1_release", core_reset, 0);
    check_output("t1_done",    load_done,  1);
    check_output("t1_count",   word_count, 3);
    for (int i = 0; i < DEPTH; i++)
      check_output("t1_mem", mem[i], (i < 3) ? img[i] : NOP);

    // Same image with two idle cycles between words
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(img[i], i == 2);
      check_output("t2_addr", bus.imem_addr,  64'(i * 4));
      check_output("t2_data", bus.imem_wdata, img[i]);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          check_output("t2_gap_we", bus.imem_we, 0);
        end
      end
    end
    for (int i = 0; i < 40 && !load_done; i++) tick();
    check_output("t2_done_timeout", load_done, 1);
    for (int i = 0; i < DEPTH; i++)
      check_output("t2_mem", mem[i], (i < 3) ? img[i] : NOP);

    // Full image, last on word 8: no padding, release four edges later
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(32'h1000 + 32'(i), i == 7);
      check_output("t3_addr", bus.imem_addr,  64'(i * 4));
      check_output("t3_data", bus.imem_wdata, 32'h1000 + 32'(i));
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("t3_hold_we",   bus.imem_we, 0);
      check_output("t3_hold_crst", core_reset,  1);
    end
    tick();
    check_output("t3_release", core_reset, 0);
    check_output("t3_done",    load_done,  1);
    check_output("t3_count",   word_count, 8);

    // RUN ignores upstream activity
    for (int i = 0; i < 20; i++) begin
      bus.s_valid = i[0];
      bus.s_data  = $urandom;
      bus.s_last  = i[1];
      tick();
      check_output("run_we",    bus.imem_we, 0);
      check_output("run_crst",  core_reset,  0);
      check_output("run_count", word_count,  8);
    end

    // Eight words without last: overflow, no ninth write, core stays in reset
    do_reset();
    for (int i = 0; i < 8; i++) apply_stimulus(32'h2000 + 32'(i), 1'b0);
    check_output("t4_addr",     bus.imem_addr, 28);
    check_output("t4_overflow", overflow,      1);
    check_output("t4_ready",    bus.s_ready,   0);
    check_output("t4_count",    word_count,    8);
    apply_stimulus(32'h3000, 1'b0);
    check_output("t4_ninth_we",    bus.imem_we, 0);
    check_output("t4_ninth_count", word_count,  8);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_output("t4_crst", core_reset, 1);
    end
    check_output("t4_done", load_done, 0);

    // Reset in the middle of a load, then a clean reload from address 0
    do_reset();
    apply_stimulus(img[0], 1'b0);
    apply_stimulus(img[1], 1'b0);
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    check_reset_values("t5_rst");
    reset = 1'b0;
    tick();
    check_output("t5_ready_back", bus.s_ready, 1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(img[i], i == 2);
      check_output("t5_addr", bus.imem_addr,  64'(i * 4));
      check_output("t5_data", bus.imem_wdata, img[i]);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 40 && !load_done; i++) tick();
    check_output("t5_done",  load_done,  1);
    check_output("t5_count", word_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
